// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: halt-sequencer states, latch stage indices and
// the per-stage bit-vector type used by the latch controller.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pl_state_t;

  localparam int IFID  = 0;
  localparam int IDEX  = 1;
  localparam int EXMEM = 2;
  localparam int MEMWB = 3;

  typedef logic [3:0] stgvec_t;

  function automatic logic [2:0] popcount4(input stgvec_t v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/pipeline_latch_ctrl_if.sv
// Hazard-unit request bundle in, latch strobes, tokens and counters out.
interface pipeline_latch_ctrl_if #(parameter int CNT_W = 32);
  import cpu_types_pkg::*;

  logic             ihit;
  logic             dhit;
  stgvec_t          flush_req;
  stgvec_t          freeze_req;
  logic             pc_freeze;
  logic             pc_en_bj;
  logic             id_halt;
  logic             pc_en;
  stgvec_t          lat_en;
  stgvec_t          lat_clr;
  stgvec_t          stg_valid;
  logic             halt;
  pl_state_t        state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport plc (
    input  ihit, dhit, flush_req, freeze_req, pc_freeze, pc_en_bj, id_halt,
    output pc_en, lat_en, lat_clr, stg_valid, halt, state, stall_cnt, flush_cnt
  );

  modport tb (
    output ihit, dhit, flush_req, freeze_req, pc_freeze, pc_en_bj, id_halt,
    input  pc_en, lat_en, lat_clr, stg_valid, halt, state, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Performance counter that adds 0..4 per enabled cycle and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             en,
  input  logic [2:0]       inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W:0] sum;

  // One extra bit catches the carry-out so overflow clamps instead of wrapping.
  assign sum = {1'b0, cnt} + (CNT_W + 1)'(inc);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/pipeline_latch_ctrl.sv
// Converts per-stage flush/freeze requests into PC/latch strobes, tracks valid
// and halt tokens, sequences halt (RUN/DRAIN/HALTED) and counts stalls/flushes.
module pipeline_latch_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int NSTG  = 4
) (
  input logic               CLK,
  input logic               nRST,
  pipeline_latch_ctrl_if.plc bus
);

  if (NSTG != 4) begin : g_nstg_check
    $error("pipeline_latch_ctrl supports only NSTG == 4");
  end

  pl_state_t state_q, state_d;
  stgvec_t   valid_q, valid_d;
  stgvec_t   htok_q, htok_d;
  stgvec_t   pend_q, pend_d;
  logic      redirect_q, redirect_d;
  stgvec_t   flush_hit;
  stgvec_t   prev_valid, prev_htok, bubble;
  logic      fetch_tok, go_drain, retire, wrong_path;
  logic [2:0] stall_inc, flush_inc;

  assign fetch_tok = bus.ihit & (state_q == RUN);
  assign go_drain  = (state_q == RUN) & bus.id_halt & ~bus.freeze_req[IFID]
                     & ~bus.flush_req[IFID] & ~pend_q[IFID];
  // The halt token is born in ID/EX, so IF/ID never carries one.
  assign prev_valid = {valid_q[2:0], fetch_tok};
  assign prev_htok  = {htok_q[2:1], go_drain, 1'b0};
  assign bubble     = {3'b000, ~fetch_tok};

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    htok_d     = htok_q;
    pend_d     = pend_q;
    redirect_d = redirect_q;
    flush_hit  = '0;
    bus.pc_en  = 1'b0;
    bus.lat_en = '0;
    bus.lat_clr = '0;
    bus.halt   = 1'b0;
    retire     = 1'b0;
    wrong_path = 1'b0;

    if (!nRST) begin
      bus.lat_clr = '1;
    end else if (state_q == HALTED) begin
      bus.halt = 1'b1;
    end else begin
      for (int s = 0; s < 4; s++) begin
        if (bus.freeze_req[s]) begin
          pend_d[s] = pend_q[s] | bus.flush_req[s];
        end else if (bus.flush_req[s] | pend_q[s]) begin
          bus.lat_en[s]  = 1'b1;
          bus.lat_clr[s] = 1'b1;
          valid_d[s]     = 1'b0;
          htok_d[s]      = 1'b0;
          pend_d[s]      = 1'b0;
          flush_hit[s]   = 1'b1;
        end else begin
          bus.lat_en[s]  = 1'b1;
          bus.lat_clr[s] = bubble[s];
          valid_d[s]     = prev_valid[s];
          htok_d[s]      = prev_htok[s];
        end
      end

      bus.pc_en = (state_q == RUN) & ~bus.pc_freeze
                  & (bus.ihit | bus.pc_en_bj | redirect_q);
      // A redirect that lands under pc_freeze is remembered until the PC can load.
      if (bus.pc_freeze & bus.pc_en_bj) begin
        redirect_d = 1'b1;
      end else if (bus.pc_en) begin
        redirect_d = 1'b0;
      end

      retire     = htok_q[MEMWB] & ~bus.freeze_req[MEMWB] & bus.dhit;
      wrong_path = |(htok_q[2:0] & flush_hit[2:0]);
      case (state_q)
        RUN:     if (go_drain) state_d = DRAIN;
        DRAIN:   if (retire) state_d = HALTED;
                 else if (wrong_path) state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= RUN;
      valid_q    <= '0;
      htok_q     <= '0;
      pend_q     <= '0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      htok_q     <= htok_d;
      pend_q     <= pend_d;
      redirect_q <= redirect_d;
    end
  end

  assign bus.stg_valid = valid_q;
  assign bus.state     = state_q;
  assign stall_inc     = {2'b00, (|bus.freeze_req) | bus.pc_freeze};
  assign flush_inc     = popcount4(flush_hit);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .en   (state_q != HALTED),
    .inc  (stall_inc),
    .cnt  (bus.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .en   (state_q != HALTED),
    .inc  (flush_inc),
    .cnt  (bus.flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_latch_ctrl.sv
// Directed bench for pipeline_latch_ctrl; counters use CNT_W=8 so saturation
// is reachable in a few dozen cycles.
module tb_pipeline_latch_ctrl;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  pipeline_latch_ctrl_if #(.CNT_W(8)) bus ();

  pipeline_latch_ctrl #(.CNT_W(8), .NSTG(4)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; combinational strobes are sampled 1ns later.
  task automatic applyStimulus(input logic ih, input stgvec_t fl, input stgvec_t fz,
                               input logic pcf, input logic bj, input logic idh);
    @(negedge clk);
    bus.ihit       = ih;
    bus.flush_req  = fl;
    bus.freeze_req = fz;
    bus.pc_freeze  = pcf;
    bus.pc_en_bj   = bj;
    bus.id_halt    = idh;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    bus.ihit = 1'b0; bus.dhit = 1'b1; bus.flush_req = '0; bus.freeze_req = '0;
    bus.pc_freeze = 1'b0; bus.pc_en_bj = 1'b0; bus.id_halt = 1'b0;
    #1;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic fill_pipe();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    nrst = 1'b0;
    bus.ihit = 1'b1; bus.dhit = 1'b1; bus.flush_req = '0; bus.freeze_req = '0;
    bus.pc_freeze = 1'b0; bus.pc_en_bj = 1'b0; bus.id_halt = 1'b0;
    #1;
    vectors++; if (bus.pc_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pc_en: got %b want 0", bus.pc_en); end
    vectors++; if (bus.lat_en !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_lat_en: got %b want 0000", bus.lat_en); end
    vectors++; if (bus.lat_clr !== 4'b1111) begin miscompares++; $display("[TB] FAIL reset_lat_clr: got %b want 1111", bus.lat_clr); end
    vectors++; if (bus.halt !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_halt: got %b want 0", bus.halt); end
    vectors++; if (bus.state !== RUN) begin miscompares++; $display("[TB] FAIL reset_state: got %0d want 0", bus.state); end
    vectors++; if (bus.stg_valid !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_valid: got %b want 0000", bus.stg_valid); end
    vectors++; if (bus.stall_cnt !== 8'd0 || bus.flush_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_cnts: got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt); end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_fill();
    stgvec_t exp_v[4];
    exp_v[0] = 4'b0001; exp_v[1] = 4'b0011; exp_v[2] = 4'b0111; exp_v[3] = 4'b1111;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      vectors++; if (bus.pc_en !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_pc_en[%0d]: got %b want 1", i, bus.pc_en); end
      tick();
      vectors++; if (bus.stg_valid !== exp_v[i]) begin miscompares++; $display("[TB] FAIL fill_valid[%0d]: got %b want %b", i, bus.stg_valid, exp_v[i]); end
    end
    vectors++; if (bus.stall_cnt !== 8'd0 || bus.flush_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL fill_cnts: got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt); end
  endtask

  // Continues from the full pipeline left by test_fill.
  task automatic test_freeze_flush();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 4'b0010, 4'b0011, 1'b0, 1'b0, 1'b0);
      vectors++; if (bus.lat_en !== 4'b1100 || bus.lat_clr !== 4'b0000) begin miscompares++; $display("[TB] FAIL frz_strobes[%0d]: got en=%b clr=%b want 1100/0000", i, bus.lat_en, bus.lat_clr); end
      tick();
    end
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    vectors++; if (bus.lat_clr !== 4'b0010 || bus.lat_en !== 4'b1111) begin miscompares++; $display("[TB] FAIL frz_release: got en=%b clr=%b want 1111/0010", bus.lat_en, bus.lat_clr); end
    tick();
    vectors++; if (bus.stg_valid !== 4'b1101) begin miscompares++; $display("[TB] FAIL frz_valid: got %b want 1101", bus.stg_valid); end
    vectors++; if (bus.flush_cnt !== 8'd1 || bus.stall_cnt !== 8'd2) begin miscompares++; $display("[TB] FAIL frz_cnts: got flush=%0d stall=%0d want 1/2", bus.flush_cnt, bus.stall_cnt); end
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    vectors++; if (bus.lat_clr !== 4'b0000) begin miscompares++; $display("[TB] FAIL frz_pend_cleared: got %b want 0000", bus.lat_clr); end
    tick();
    vectors++; if (bus.stg_valid !== 4'b1011) begin miscompares++; $display("[TB] FAIL frz_valid2: got %b want 1011", bus.stg_valid); end
  endtask

  task automatic test_pc_redirect();
    do_reset();
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
    vectors++; if (bus.pc_en !== 1'b0) begin miscompares++; $display("[TB] FAIL redir_frozen: got %b want 0", bus.pc_en); end
    tick();
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    vectors++; if (bus.pc_en !== 1'b1) begin miscompares++; $display("[TB] FAIL redir_release: got %b want 1", bus.pc_en); end
    tick();
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    vectors++; if (bus.pc_en !== 1'b0) begin miscompares++; $display("[TB] FAIL redir_once: got %b want 0", bus.pc_en); end
    tick();
    vectors++; if (bus.stall_cnt !== 8'd1) begin miscompares++; $display("[TB] FAIL redir_stall: got %0d want 1", bus.stall_cnt); end
  endtask

  task automatic test_halt();
    do_reset();
    fill_pipe();
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    tick();
    vectors++; if (bus.state !== DRAIN) begin miscompares++; $display("[TB] FAIL halt_enter: got %0d want 1", bus.state); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (bus.halt !== 1'b0) begin miscompares++; $display("[TB] FAIL halt_early[%0d]: got %b want 0", i, bus.halt); end
      applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      vectors++; if (bus.pc_en !== 1'b0) begin miscompares++; $display("[TB] FAIL halt_drain_pc_en[%0d]: got %b want 0", i, bus.pc_en); end
      tick();
    end
    vectors++; if (bus.halt !== 1'b1 || bus.state !== HALTED) begin miscompares++; $display("[TB] FAIL halt_reached: got halt=%b state=%0d want 1/2", bus.halt, bus.state); end
    applyStimulus(1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
    vectors++; if (bus.lat_en !== 4'b0000 || bus.pc_en !== 1'b0) begin miscompares++; $display("[TB] FAIL halted_strobes: got en=%b pc=%b want 0000/0", bus.lat_en, bus.pc_en); end
    tick();
    vectors++; if (bus.stall_cnt !== 8'd0 || bus.halt !== 1'b1) begin miscompares++; $display("[TB] FAIL halted_frozen: got stall=%0d halt=%b want 0/1", bus.stall_cnt, bus.halt); end
  endtask

  task automatic test_wrong_path_halt();
    do_reset();
    fill_pipe();
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
    vectors++; if (bus.lat_clr !== 4'b0101) begin miscompares++; $display("[TB] FAIL wp_clr: got %b want 0101", bus.lat_clr); end
    tick();
    vectors++; if (bus.state !== RUN || bus.halt !== 1'b0) begin miscompares++; $display("[TB] FAIL wp_state: got state=%0d halt=%b want 0/0", bus.state, bus.halt); end
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    vectors++; if (bus.pc_en !== 1'b1) begin miscompares++; $display("[TB] FAIL wp_fetch: got %b want 1", bus.pc_en); end
    tick();
    vectors++; if (bus.stg_valid[IFID] !== 1'b1 || bus.flush_cnt !== 8'd1) begin miscompares++; $display("[TB] FAIL wp_resume: got v0=%b flush=%0d want 1/1", bus.stg_valid[IFID], bus.flush_cnt); end
  endtask

  task automatic test_all_flush_freeze();
    do_reset();
    fill_pipe();
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
    vectors++; if (bus.lat_en !== 4'b0000 || bus.lat_clr !== 4'b0000) begin miscompares++; $display("[TB] FAIL all_hold: got en=%b clr=%b want 0000/0000", bus.lat_en, bus.lat_clr); end
    tick();
    vectors++; if (bus.stg_valid !== 4'b1111 || bus.flush_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL all_held: got v=%b flush=%0d want 1111/0", bus.stg_valid, bus.flush_cnt); end
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    vectors++; if (bus.lat_clr !== 4'b1111) begin miscompares++; $display("[TB] FAIL all_release: got %b want 1111", bus.lat_clr); end
    tick();
    vectors++; if (bus.stg_valid !== 4'b0000 || bus.flush_cnt !== 8'd4) begin miscompares++; $display("[TB] FAIL all_applied: got v=%b flush=%0d want 0000/4", bus.stg_valid, bus.flush_cnt); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 63; i++) begin
      applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
      tick();
    end
    vectors++; if (bus.flush_cnt !== 8'hFC) begin miscompares++; $display("[TB] FAIL sat_preload: got %h want fc", bus.flush_cnt); end
    applyStimulus(1'b1, 4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.flush_cnt !== 8'hFE) begin miscompares++; $display("[TB] FAIL sat_near: got %h want fe", bus.flush_cnt); end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
      tick();
      vectors++; if (bus.flush_cnt !== 8'hFF) begin miscompares++; $display("[TB] FAIL sat_clamp[%0d]: got %h want ff", i, bus.flush_cnt); end
    end
  endtask

  task automatic test_reset_mid_drain();
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    tick();
    vectors++; if (bus.state !== DRAIN) begin miscompares++; $display("[TB] FAIL mid_drain_enter: got %0d want 1", bus.state); end
    @(negedge clk);
    nrst = 1'b0;
    bus.id_halt = 1'b0;
    #1;
    vectors++; if (bus.state !== RUN || bus.stg_valid !== 4'b0000) begin miscompares++; $display("[TB] FAIL mid_drain_reset: got state=%0d v=%b want 0/0000", bus.state, bus.stg_valid); end
    vectors++; if (bus.flush_cnt !== 8'd0 || bus.lat_clr !== 4'b1111 || bus.pc_en !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_drain_outs: got flush=%0d clr=%b pc=%b want 0/1111/0", bus.flush_cnt, bus.lat_clr, bus.pc_en); end
    @(negedge clk);
    nrst = 1'b1;
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    vectors++; if (bus.pc_en !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_drain_fetch: got %b want 1", bus.pc_en); end
    tick();
  endtask

  initial begin
    bus.ihit = 1'b0; bus.dhit = 1'b1; bus.flush_req = '0; bus.freeze_req = '0;
    bus.pc_freeze = 1'b0; bus.pc_en_bj = 1'b0; bus.id_halt = 1'b0;
    test_reset();
    test_fill();
    test_freeze_flush();
    test_pc_redirect();
    test_halt();
    test_wrong_path_halt();
    test_all_flush_freeze();
    test_saturate();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
